// File: rtl/rf_write_scheduler_pkg.sv
// Shared types and constants for the register-file write scheduler and its LL result queue.
package rf_write_scheduler_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wa;
    logic [DATA_W-1:0]     wd;
  } ll_entry_t;

  // Winner of the single Reg_File write port in a given cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_LL   = 2'd2
  } wr_src_e;

endpackage

// File: rtl/rf_write_scheduler_if.sv
// Issue, writeback, LL-result and Reg_File write-port signals of the write scheduler.
interface rf_write_scheduler_if;
  import rf_write_scheduler_pkg::*;

  logic                  ISS_VALID;
  logic [REG_ADDR_W-1:0] ISS_RS;
  logic [REG_ADDR_W-1:0] ISS_RT;
  logic [REG_ADDR_W-1:0] ISS_RD;
  logic                  ISS_WE;
  logic                  ISS_LL;
  logic                  ISS_STALL;
  logic                  WB_VALID;
  logic [REG_ADDR_W-1:0] WB_WA;
  logic [DATA_W-1:0]     WB_WD;
  logic                  LL_VALID;
  logic [REG_ADDR_W-1:0] LL_WA;
  logic [DATA_W-1:0]     LL_WD;
  logic                  LL_READY;
  logic                  RFWE;
  logic [REG_ADDR_W-1:0] RFWA;
  logic [DATA_W-1:0]     RFWD;

  modport master (
    output ISS_VALID, ISS_RS, ISS_RT, ISS_RD, ISS_WE, ISS_LL,
    output WB_VALID, WB_WA, WB_WD, LL_VALID, LL_WA, LL_WD,
    input  ISS_STALL, LL_READY, RFWE, RFWA, RFWD
  );

  modport slave (
    input  ISS_VALID, ISS_RS, ISS_RT, ISS_RD, ISS_WE, ISS_LL,
    input  WB_VALID, WB_WA, WB_WD, LL_VALID, LL_WA, LL_WD,
    output ISS_STALL, LL_READY, RFWE, RFWA, RFWD
  );

endinterface

// File: rtl/rf_write_scheduler_ll_fifo.sv
// DEPTH-entry synchronous FIFO holding long-latency results until they win the write port.
module rf_ll_fifo
  import rf_write_scheduler_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  ll_entry_t        wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output ll_entry_t        head_o
);

  ll_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Owns the Reg_File write port: WB-over-LL arbitration, LL busy scoreboard and starvation stall.
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  rf_write_scheduler_if.slave bus
);

  localparam int         CNT_W      = $clog2(DEPTH + 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  ll_entry_t        fifo_head, ll_in;
  logic             ll_ready, ll_push, ll_pop;
  logic             starve_force, issue_fire, busy_set;
  wr_src_e          wr_src;

  logic [31:0]           busy_q, busy_d;
  logic [3:0]            starve_q, starve_d;
  logic                  rfwe_q;
  logic [REG_ADDR_W-1:0] rfwa_q;
  logic [DATA_W-1:0]     rfwd_q;

  assign ll_ready = (fifo_count < CNT_W'(DEPTH));
  assign ll_push  = bus.LL_VALID && ll_ready && !fifo_full;
  assign ll_in    = '{wa: bus.LL_WA, wd: bus.LL_WD};

  rf_ll_fifo #(.DEPTH(DEPTH)) u_ll_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (ll_push),
    .pop_i   (ll_pop),
    .wdata_i (ll_in),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // WB always wins; the queue head only drains in WB bubbles.
  assign wr_src = bus.WB_VALID ? SRC_WB : (!fifo_empty ? SRC_LL : SRC_NONE);
  assign ll_pop = (wr_src == SRC_LL);

  assign starve_force = (starve_q >= STARVE_MAX);

  // Stall reads registered busy only, so a clear releases the stall one cycle later.
  assign bus.ISS_STALL = bus.ISS_VALID && (
      ((bus.ISS_RS != REG_ZERO) && busy_q[bus.ISS_RS]) ||
      ((bus.ISS_RT != REG_ZERO) && busy_q[bus.ISS_RT]) ||
      (bus.ISS_WE && (bus.ISS_RD != REG_ZERO) && busy_q[bus.ISS_RD]) ||
      starve_force);

  assign issue_fire = bus.ISS_VALID && !bus.ISS_STALL;
  assign busy_set   = issue_fire && bus.ISS_WE && bus.ISS_LL && (bus.ISS_RD != REG_ZERO);

  // NOTE: combinational blocks assign a default first so no path leaves a variable unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    if (ll_pop)   busy_d[fifo_head.wa] = 1'b0;
    if (busy_set) busy_d[bus.ISS_RD]   = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || ll_pop)      starve_d = '0;
    else if (starve_q < STARVE_MAX) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      busy_q   <= '0;
      starve_q <= '0;
      rfwe_q   <= 1'b0;
      rfwa_q   <= '0;
      rfwd_q   <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
      case (wr_src)
        SRC_WB: begin
          rfwe_q <= (bus.WB_WA != REG_ZERO);
          rfwa_q <= bus.WB_WA;
          rfwd_q <= bus.WB_WD;
        end
        SRC_LL: begin
          rfwe_q <= (fifo_head.wa != REG_ZERO);
          rfwa_q <= fifo_head.wa;
          rfwd_q <= fifo_head.wd;
        end
        default: rfwe_q <= 1'b0;
      endcase
    end
  end

  assign bus.LL_READY = ll_ready;
  assign bus.RFWE     = rfwe_q;
  assign bus.RFWA     = rfwa_q;
  assign bus.RFWD     = rfwd_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench: expected Reg_File writes are queued with their due cycle and checked every cycle.
module tb_rf_write_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    int          due;
  } exp_t;

  exp_t sb[$];

  rf_write_scheduler_if bus ();

  rf_write_scheduler #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd, input int due);
    exp_t e;
    e.wa = wa; e.wd = wd; e.due = due;
    sb.push_back(e);
  endtask

  // Every cycle: either the queued write due now appears, or the port is idle.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rfwe", 32'(bus.RFWE), 32'd1);
      chk("rfwa", 32'(bus.RFWA), 32'(e.wa));
      chk("rfwd", bus.RFWD, e.wd);
    end else begin
      chk("rfwe_idle", 32'(bus.RFWE), 32'd0);
    end
  endtask

  task automatic iss(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic we, input logic ll);
    bus.ISS_VALID = v; bus.ISS_RS = rs; bus.ISS_RT = rt;
    bus.ISS_RD = rd; bus.ISS_WE = we; bus.ISS_LL = ll;
  endtask

  task automatic wb(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.WB_VALID = v; bus.WB_WA = wa; bus.WB_WD = wd;
  endtask

  task automatic ll(input logic v, input logic [4:0] wa, input logic [31:0] wd);
    bus.LL_VALID = v; bus.LL_WA = wa; bus.LL_WD = wd;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    iss(0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    ll(0, 0, 0);

    // 1. Reset values and idle behaviour.
    #12;
    chk("rst_rfwe", 32'(bus.RFWE), 32'd0);
    chk("rst_rfwa", 32'(bus.RFWA), 32'd0);
    chk("rst_rfwd", bus.RFWD, 32'd0);
    chk("rst_ll_ready", 32'(bus.LL_READY), 32'd1);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      iss(1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
          5'($urandom_range(1, 31)), 1'b1, 1'b0);
      #1 chk("idle_stall", 32'(bus.ISS_STALL), 32'd0);
      chk("idle_ll_ready", 32'(bus.LL_READY), 32'd1);
      tick();
    end

    // 2. LL to r7: RAW stall until one cycle after the pop edge.
    iss(1, 0, 0, 7, 1, 1);
    #1 chk("ll7_issue_stall", 32'(bus.ISS_STALL), 32'd0);
    tick();
    iss(1, 7, 0, 8, 1, 0);
    ll(1, 7, 32'hDEADBEEF);
    #1 chk("raw7_stall", 32'(bus.ISS_STALL), 32'd1);
    chk("ll7_ready", 32'(bus.LL_READY), 32'd1);
    expect_wr(7, 32'hDEADBEEF, cyc + 2);
    tick();
    ll(0, 0, 0);
    #1 chk("raw7_stall_queued", 32'(bus.ISS_STALL), 32'd1);
    tick();
    chk("raw7_release", 32'(bus.ISS_STALL), 32'd0);
    tick();
    iss(0, 0, 0, 0, 0, 0);

    // 3. WB and LL in the same cycle: WB first, LL one cycle later.
    wb(1, 3, 32'h11);
    ll(1, 5, 32'h22);
    expect_wr(3, 32'h11, cyc + 1);
    expect_wr(5, 32'h22, cyc + 2);
    tick();
    wb(0, 0, 0);
    ll(0, 0, 0);
    tick();
    tick();

    // 4. WB held: queue fills, starvation forces stall, then drains in order.
    iss(1, 1, 2, 3, 1, 0);
    wb(1, 10, 32'h100);
    ll(1, 12, 32'hA1);
    expect_wr(10, 32'h100, cyc + 1);
    tick();
    wb(1, 10, 32'h101);
    ll(1, 13, 32'hA2);
    expect_wr(10, 32'h101, cyc + 1);
    #1 chk("q1_ll_ready", 32'(bus.LL_READY), 32'd1);
    tick();
    ll(0, 0, 0);
    chk("qfull_ll_ready", 32'(bus.LL_READY), 32'd0);
    chk("starve1_stall", 32'(bus.ISS_STALL), 32'd0);
    for (int i = 0; i < 3; i++) begin
      wb(1, 10, 32'h102 + 32'(i));
      expect_wr(10, 32'h102 + 32'(i), cyc + 1);
      tick();
      chk("qfull_hold_ready", 32'(bus.LL_READY), 32'd0);
      chk("starve_stall", 32'(bus.ISS_STALL), (i == 2) ? 32'd1 : 32'd0);
    end
    wb(0, 0, 0);
    expect_wr(12, 32'hA1, cyc + 1);
    expect_wr(13, 32'hA2, cyc + 2);
    tick();
    chk("drain_stall", 32'(bus.ISS_STALL), 32'd0);
    chk("drain_ll_ready", 32'(bus.LL_READY), 32'd1);
    tick();
    chk("empty_ll_ready", 32'(bus.LL_READY), 32'd1);
    iss(0, 0, 0, 0, 0, 0);
    tick();

    // 5. Register 0: writes are consumed silently, never busy, never stalls.
    wb(1, 0, 32'h55);
    tick();
    wb(0, 0, 0);
    ll(1, 0, 32'h66);
    tick();
    ll(0, 0, 0);
    tick();
    iss(1, 0, 0, 0, 1, 1);
    #1 chk("r0_ll_issue", 32'(bus.ISS_STALL), 32'd0);
    tick();
    iss(1, 0, 0, 0, 1, 0);
    #1 chk("r0_no_stall", 32'(bus.ISS_STALL), 32'd0);
    tick();

    // 6. WAW on r9: second writer waits for the LL result to pop.
    iss(1, 0, 0, 9, 1, 1);
    tick();
    iss(1, 1, 2, 9, 1, 0);
    #1 chk("waw9_stall", 32'(bus.ISS_STALL), 32'd1);
    tick();
    chk("waw9_stall_hold", 32'(bus.ISS_STALL), 32'd1);
    ll(1, 9, 32'h99);
    expect_wr(9, 32'h99, cyc + 2);
    tick();
    ll(0, 0, 0);
    #1 chk("waw9_stall_queued", 32'(bus.ISS_STALL), 32'd1);
    tick();
    chk("waw9_release", 32'(bus.ISS_STALL), 32'd0);
    tick();
    iss(0, 0, 0, 0, 0, 0);

    // 7. Asynchronous reset mid-cycle drops RFWE and discards a queued LL result.
    wb(1, 4, 32'h44);
    ll(1, 6, 32'h66);
    expect_wr(4, 32'h44, cyc + 1);
    tick();
    wb(0, 0, 0);
    ll(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rfwe", 32'(bus.RFWE), 32'd0);
    chk("async_rfwa", 32'(bus.RFWA), 32'd0);
    chk("async_rfwd", bus.RFWD, 32'd0);
    chk("async_ll_ready", 32'(bus.LL_READY), 32'd1);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
